// File: rtl/slave_mailbox_pkg.sv
// Shared definitions for the slave mailbox: register offsets, FSM states,
// STATUS/CONTROL bit positions and the captured-request struct.
package slave_mailbox_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int ST_EMPTY_BIT = 9;
  localparam int ST_FULL_BIT  = 10;
  localparam int ST_OVF_BIT   = 11;
  localparam int ST_UDF_BIT   = 12;

  localparam int CTL_FLUSH_BIT = 0;
  localparam int CTL_CLR_BIT   = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } mbox_state_t;

  typedef struct packed {
    logic [1:0]  sel;
    logic        wr;
    logic [31:0] wdata;
  } mbox_req_t;

endpackage

// File: rtl/mailbox_fifo.sv
// Mailbox storage: DEPTH-entry circular FIFO with push/pop/flush.
// Illegal pushes (full) and pops (empty) are silently ignored here.
module mailbox_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] wdata,
  output logic [31:0] head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output logic [AW:0] count_nxt
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rptr];

  always_comb begin
    count_nxt = count;
    if (flush)                  count_nxt = '0;
    else if (do_push && !do_pop) count_nxt = count + 1'b1;
    else if (do_pop && !do_push) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (do_push) wptr <= wptr + 1'b1;
        if (do_pop)  rptr <= rptr + 1'b1;
      end
    end
  end

  // Storage is not reset; only pointers/count define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/slave_mailbox.sv
// Crossbar slave exposing a mailbox FIFO with DATA/STATUS/CONTROL registers.
// Optional registered interrupt output mbox_irq under SLAVE_MAILBOX_IRQ_EN.
module slave_mailbox #(
  parameter int DEPTH       = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        slave_req,
  input  logic [31:0] slave_addr,
  input  logic        slave_cmd,
  input  logic [31:0] slave_wdata,
  output logic        slave_ack,
  output logic [31:0] slave_rdata
`ifdef SLAVE_MAILBOX_IRQ_EN
  ,
  output logic        mbox_irq
`endif
);
  import slave_mailbox_pkg::*;

  localparam int AW = $clog2(DEPTH);

  mbox_state_t state, state_nxt;
  logic [3:0]  wcnt, wcnt_nxt;
  mbox_req_t   req_q, req_nxt;
  logic        ovf, udf, ovf_nxt, udf_nxt;
  logic        done, push, pop, flush, clr;
  logic [31:0] head, rdata_mux;
  logic        full, empty;
  logic [AW:0] count, count_nxt;
  logic        unused_addr;

  assign unused_addr = ^{slave_addr[31:4], slave_addr[1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      wcnt  <= '0;
      req_q <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      req_q <= req_nxt;
      ovf   <= ovf_nxt;
      udf   <= udf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    req_nxt   = req_q;
    case (state)
      ST_IDLE: if (slave_req) begin
        req_nxt   = '{sel: slave_addr[3:2], wr: slave_cmd, wdata: slave_wdata};
        wcnt_nxt  = WAIT_CYCLES[3:0];
        state_nxt = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
      end
      ST_WAIT: begin
        wcnt_nxt = wcnt - 4'd1;
        if (wcnt <= 4'd1) state_nxt = ST_ACK;
      end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // All side effects fire on the single edge that leaves ACK.
  assign done  = (state == ST_ACK);
  assign push  = done &  req_q.wr & (req_q.sel == REG_DATA);
  assign pop   = done & ~req_q.wr & (req_q.sel == REG_DATA);
  assign flush = done &  req_q.wr & (req_q.sel == REG_CTRL) & req_q.wdata[CTL_FLUSH_BIT];
  assign clr   = done &  req_q.wr & (req_q.sel == REG_CTRL) & req_q.wdata[CTL_CLR_BIT];

  assign ovf_nxt = clr ? 1'b0 : (ovf | (push & full));
  assign udf_nxt = clr ? 1'b0 : (udf | (pop & empty));

  mailbox_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .wdata    (req_q.wdata),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .count_nxt(count_nxt)
  );

  always_comb begin
    rdata_mux = '0;
    if (!req_q.wr) begin
      case (req_q.sel)
        REG_DATA:   rdata_mux = empty ? 32'd0 : head;
        REG_STATUS: begin
          rdata_mux[8:0]         = 9'(count);
          rdata_mux[ST_EMPTY_BIT] = empty;
          rdata_mux[ST_FULL_BIT]  = full;
          rdata_mux[ST_OVF_BIT]   = ovf;
          rdata_mux[ST_UDF_BIT]   = udf;
        end
        default:    rdata_mux = '0;
      endcase
    end
  end

  assign slave_ack   = done;
  assign slave_rdata = done ? rdata_mux : 32'd0;

`ifdef SLAVE_MAILBOX_IRQ_EN
  // Driven from next-state values so irq tracks the edge that applies the side effect.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) mbox_irq <= 1'b0;
    else         mbox_irq <= (count_nxt != '0) | ovf_nxt | udf_nxt;
  end
`else
  logic unused_cnt;
  assign unused_cnt = ^count_nxt;
`endif

endmodule

// File: tb/tb_slave_mailbox.sv
// Directed self-checking bench for slave_mailbox (DEPTH=8, WAIT_CYCLES=1).
// Define SLAVE_MAILBOX_IRQ_EN to also check mbox_irq.
module tb_slave_mailbox;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        slave_req = 1'b0;
  logic [31:0] slave_addr = '0;
  logic        slave_cmd = 1'b0;
  logic [31:0] slave_wdata = '0;
  logic        slave_ack;
  logic [31:0] slave_rdata;
`ifdef SLAVE_MAILBOX_IRQ_EN
  logic        mbox_irq;
`endif

  int total = 0;
  int bad = 0;
  int idle_rdata_bad = 0;

  always #5 clk = ~clk;

  slave_mailbox #(.DEPTH(8), .WAIT_CYCLES(1)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .slave_req  (slave_req),
    .slave_addr (slave_addr),
    .slave_cmd  (slave_cmd),
    .slave_wdata(slave_wdata),
    .slave_ack  (slave_ack),
    .slave_rdata(slave_rdata)
`ifdef SLAVE_MAILBOX_IRQ_EN
    ,
    .mbox_irq   (mbox_irq)
`endif
  );

  always @(negedge clk) if (!slave_ack && slave_rdata != 32'd0) idle_rdata_bad++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction; returns read data and number of negedges until ack.
  task automatic bus(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output int lat);
    @(negedge clk);
    slave_req = 1'b1; slave_cmd = wr; slave_addr = a; slave_wdata = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!slave_ack && lat < 20);
    if (!slave_ack) chk("ack_timeout", 32'(lat), 32'd2);
    rd = slave_rdata;
    slave_req = 1'b0;
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd; int lat;
    bus(1'b1, a, d, rd, lat);
  endtask

  task automatic rd32(input logic [31:0] a, output logic [31:0] rd);
    int lat;
    bus(1'b0, a, 32'd0, rd, lat);
  endtask

  initial begin
    logic [31:0] rd;
    int lat;
    logic [7:0] pat;

    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, slave_ack}, 32'd0);
    chk("rst_rdata", slave_rdata, 32'd0);
    resetn = 1'b1;

    // Single push: ack latency and one-cycle pulse
    bus(1'b1, 32'h0, 32'hA5A5_0001, rd, lat);
    chk("push_lat", 32'(lat), 32'd2);
    @(negedge clk);
    chk("ack_pulse", {31'd0, slave_ack}, 32'd0);
    bus(1'b0, 32'h4, 32'd0, rd, lat);
    chk("stat_one", rd, 32'h0000_0001);
    chk("read_lat", 32'(lat), 32'd2);
    rd32(32'h0, rd);
    chk("pop_a5", rd, 32'hA5A5_0001);

    // FIFO ordering
    wr32(32'h0, 32'h11); wr32(32'h0, 32'h22); wr32(32'h0, 32'h33);
    rd32(32'h0, rd); chk("pop_11", rd, 32'h11);
    rd32(32'h0, rd); chk("pop_22", rd, 32'h22);
    rd32(32'h0, rd); chk("pop_33", rd, 32'h33);
    rd32(32'h4, rd); chk("stat_empty", rd, 32'h0000_0200);

    // Overflow: 9 pushes, 9th dropped
    for (int i = 1; i <= 9; i++) wr32(32'h0, 32'(i));
    rd32(32'h4, rd); chk("stat_ovf", rd, 32'h0000_0C08);
    wr32(32'h8, 32'h2);
    rd32(32'h4, rd); chk("stat_clr_ovf", rd, 32'h0000_0408);
    rd32(32'h0, rd); chk("pop_first", rd, 32'd1);
    for (int i = 2; i <= 7; i++) rd32(32'h0, rd);
    rd32(32'h0, rd); chk("pop_eighth", rd, 32'd8);
    rd32(32'h4, rd); chk("stat_drained", rd, 32'h0000_0200);

    // Underflow and flush
    rd32(32'h0, rd); chk("pop_empty", rd, 32'd0);
    rd32(32'h4, rd); chk("stat_udf", rd, 32'h0000_1200);
    wr32(32'h8, 32'h2);
    rd32(32'h4, rd); chk("stat_clr_udf", rd, 32'h0000_0200);
    wr32(32'h0, 32'hA); wr32(32'h0, 32'hB); wr32(32'h0, 32'hC);
    rd32(32'h4, rd); chk("stat_three", rd, 32'h0000_0003);
    wr32(32'h8, 32'h1);
    rd32(32'h4, rd); chk("stat_flush", rd, 32'h0000_0200);
    wr32(32'h0, 32'hD);
    rd32(32'h0, rd); chk("pop_after_flush", rd, 32'hD);

    // Reserved/read-only/write-only decode, upper address bits ignored
    bus(1'b0, 32'hC, 32'd0, rd, lat);
    chk("rsvd_rd", rd, 32'd0);
    chk("rsvd_lat", 32'(lat), 32'd2);
    wr32(32'hC, 32'hFFFF_FFFF);
    wr32(32'h4, 32'hFFFF_FFFF);
    rd32(32'h8, rd); chk("ctrl_rd", rd, 32'd0);
    rd32(32'h1004, rd); chk("stat_alias", rd, 32'h0000_0200);

    // Back-to-back: req held through two writes
    @(negedge clk);
    slave_req = 1'b1; slave_cmd = 1'b1; slave_addr = 32'h0; slave_wdata = 32'h77;
    pat = '0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      pat[i] = slave_ack;
      if (i == 5) slave_req = 1'b0;
    end
    chk("b2b_ack_pat", {24'd0, pat}, 32'h0000_0024);
    rd32(32'h4, rd); chk("b2b_count", rd, 32'h0000_0002);
    wr32(32'h8, 32'h1);

    // Reset during WAIT aborts the push
    @(negedge clk);
    slave_req = 1'b1; slave_cmd = 1'b1; slave_addr = 32'h0; slave_wdata = 32'h55;
    @(negedge clk);
    resetn = 1'b0; slave_req = 1'b0;
    @(negedge clk);
    chk("rst_abort_ack", {31'd0, slave_ack}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_abort_ack2", {31'd0, slave_ack}, 32'd0);
    bus(1'b0, 32'h4, 32'd0, rd, lat);
    chk("rst_abort_stat", rd, 32'h0000_0200);
    chk("rst_abort_lat", 32'(lat), 32'd2);

`ifdef SLAVE_MAILBOX_IRQ_EN
    chk("irq_idle", {31'd0, mbox_irq}, 32'd0);
    wr32(32'h0, 32'h99);
    chk("irq_at_ack", {31'd0, mbox_irq}, 32'd0);
    @(negedge clk);
    chk("irq_rise", {31'd0, mbox_irq}, 32'd1);
    rd32(32'h0, rd);
    chk("irq_pop_data", rd, 32'h99);
    @(negedge clk);
    chk("irq_fall", {31'd0, mbox_irq}, 32'd0);
`endif

    chk("rdata_idle_zero", 32'(idle_rdata_bad), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
